// File: rtl/results_receiver.sv
// Receive side of the correlator result link: reassembles 48 UART bytes into six
// 64-bit sums and publishes them as one atomic frame, with an inter-byte timeout.
module results_receiver #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        valid,
    input  logic [7:0]  Byte_in,
    input  logic        clear,
    output logic [63:0] sum_x_2,
    output logic [63:0] sum_y_2,
    output logic [63:0] sum_xy,
    output logic [63:0] sum_xy90,
    output logic [63:0] sum_y90_2,
    output logic [63:0] sum_y_y90,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [5:0]  byte_idx
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]       LAST_IDX = 6'd47;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_COMMIT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [63:0]      r_shift;
    logic [63:0]      r_shadow [6];
    logic [63:0]      r_sums   [6];
    logic [5:0]       r_byte_idx;
    logic [CNT_W-1:0] r_timer;
    logic             r_frame_valid;
    logic             r_frame_err;

    logic             w_accept;
    logic             w_timeout;
    logic             w_commit;
    logic [63:0]      w_word;

    // Words arrive MSB byte first, so each new byte enters at the bottom.
    assign w_word   = {r_shift[55:0], Byte_in};
    assign w_commit = (r_state == S_COMMIT);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        if (clear) begin
            w_next_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        w_accept     = 1'b1;
                        w_next_state = S_RECV;
                    end
                end
                S_RECV: begin
                    if (valid) begin
                        w_accept = 1'b1;
                        if (r_byte_idx == LAST_IDX) begin
                            w_next_state = S_COMMIT;
                        end
                    end else if (r_timer == CNT_LAST) begin
                        w_timeout    = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
                S_COMMIT: begin
                    if (valid) begin
                        w_accept     = 1'b1;
                        w_next_state = S_RECV;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            // NOTE: the shadow and output arrays are small register files, reset explicitly so a
            // reset always leaves an all-zero frame visible.
            for (int i = 0; i < 6; i++) begin
                r_shadow[i] <= '0;
                r_sums[i]   <= '0;
            end
            r_shift       <= '0;
            r_byte_idx    <= '0;
            r_timer       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= w_commit;
            r_frame_err   <= w_timeout;

            // Publish happens even if clear arrives in the commit cycle.
            if (w_commit) begin
                for (int i = 0; i < 6; i++) begin
                    r_sums[i] <= r_shadow[i];
                end
            end

            if (clear || w_timeout) begin
                for (int i = 0; i < 6; i++) begin
                    r_shadow[i] <= '0;
                end
                r_shift    <= '0;
                r_byte_idx <= '0;
                r_timer    <= '0;
            end else if (w_accept) begin
                r_shift <= w_word;
                if (r_byte_idx[2:0] == 3'd7) begin
                    r_shadow[r_byte_idx[5:3]] <= w_word;
                end
                r_byte_idx <= (r_byte_idx == LAST_IDX) ? 6'd0 : r_byte_idx + 6'd1;
                r_timer    <= '0;
            end else if (r_state == S_RECV) begin
                if (r_timer != '1) begin
                    r_timer <= r_timer + CNT_W'(1);
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign sum_x_2     = r_sums[0];
    assign sum_y_2     = r_sums[1];
    assign sum_xy      = r_sums[2];
    assign sum_xy90    = r_sums[3];
    assign sum_y90_2   = r_sums[4];
    assign sum_y_y90   = r_sums[5];
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state == S_RECV);
    assign byte_idx    = r_byte_idx;

endmodule

// File: tb/tb_results_receiver.sv
// Randomised bench for results_receiver: a byte-queue reference model predicts
// frames, commit timing and timeout errors.
module tb_results_receiver;

    localparam int T = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        valid   = 1'b0;
    logic [7:0]  Byte_in = 8'h00;
    logic        clear   = 1'b0;
    logic [63:0] sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90;
    logic        frame_valid, frame_err, busy;
    logic [5:0]  byte_idx;

    results_receiver #(.TIMEOUT_CYCLES(T)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .valid      (valid),
        .Byte_in    (Byte_in),
        .clear      (clear),
        .sum_x_2    (sum_x_2),
        .sum_y_2    (sum_y_2),
        .sum_xy     (sum_xy),
        .sum_xy90   (sum_xy90),
        .sum_y90_2  (sum_y90_2),
        .sum_y_y90  (sum_y_y90),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .byte_idx   (byte_idx)
    );

    always #5 sys_clk = ~sys_clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [63:0] dut_sums [6];
    assign dut_sums[0] = sum_x_2;
    assign dut_sums[1] = sum_y_2;
    assign dut_sums[2] = sum_xy;
    assign dut_sums[3] = sum_xy90;
    assign dut_sums[4] = sum_y90_2;
    assign dut_sums[5] = sum_y_y90;

    // Reference model state
    logic [7:0]  m_bytes [$];
    logic [63:0] m_frame [6];
    logic [63:0] m_shown [6];
    int          m_fv = 0, m_fe = 0, got_fv = 0, got_fe = 0;
    int          m_commit_cyc = -10, m_last_cyc = -10;
    int          fv_cycles [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [63:0] w;
        m_bytes.push_back(b);
        m_last_cyc = cyc;
        if (m_bytes.size() == 48) begin
            for (int k = 0; k < 6; k++) begin
                w = 64'd0;
                for (int j = 0; j < 8; j++) w = w * 256 + 64'(m_bytes[8*k+j]);
                m_frame[k] = w;
            end
            m_bytes.delete();
            m_fv++;
            m_commit_cyc = cyc;
        end
    endtask

    // Pulses are checked as they happen, on the falling edge.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            if (frame_valid) begin
                got_fv++;
                fv_cycles.push_back(cyc);
                check("fv_time", 64'(cyc), 64'(m_commit_cyc + 1));
                for (int i = 0; i < 6; i++) check($sformatf("frame_sum%0d", i), dut_sums[i], m_frame[i]);
                for (int i = 0; i < 6; i++) m_shown[i] = m_frame[i];
            end
            if (frame_err) begin
                got_fe++;
                check("fe_time", 64'(cyc), 64'(m_last_cyc + T));
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        valid   = 1'b1;
        Byte_in = b;
        tick();
        valid   = 1'b0;
        model_byte(b);
        check("byte_idx", 64'(byte_idx), 64'(m_bytes.size()));
        check("busy", 64'(busy), 64'(m_bytes.size() != 0));
        repeat (gap) tick();
    endtask

    task automatic send_random(input int n, input int maxgap, input bit last_gap0);
        for (int i = 0; i < n; i++)
            send_byte(8'($urandom), (last_gap0 && i == n - 1) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic check_shown(input string tag);
        for (int i = 0; i < 6; i++) check($sformatf("%s_sum%0d", tag, i), dut_sums[i], m_shown[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            m_frame[i] = '0;
            m_shown[i] = '0;
        end
        repeat (3) tick();
        check_shown("reset");
        check("reset_fv", 64'(frame_valid), 64'd0);
        check("reset_fe", 64'(frame_err), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_idx", 64'(byte_idx), 64'd0);
        sys_rst = 1'b1;
        tick();

        // Known pattern 0x00..0x2F
        for (int i = 0; i < 48; i++) send_byte(8'(i), 5);
        repeat (3) tick();
        check("known_x2", sum_x_2, 64'h0001020304050607);
        check("known_yy90", sum_y_y90, 64'h28292A2B2C2D2E2F);
        check("known_fv_count", 64'(got_fv), 64'd1);

        // Truncated frame then timeout
        send_random(20, 3, 1'b0);
        repeat (T + 5) tick();
        m_bytes.delete();
        m_fe++;
        check("trunc_fe_count", 64'(got_fe), 64'd1);
        check("trunc_busy", 64'(busy), 64'd0);
        check("trunc_idx", 64'(byte_idx), 64'd0);
        check_shown("trunc_keep");
        send_random(48, 8, 1'b0);
        repeat (3) tick();
        check_shown("after_trunc");

        // Back-to-back frames, valid every cycle
        send_random(96, 0, 1'b1);
        repeat (3) tick();
        check("b2b_fv_count", 64'(got_fv), 64'(m_fv));
        check("b2b_spacing", 64'(fv_cycles[fv_cycles.size()-1] - fv_cycles[fv_cycles.size()-2]), 64'd48);

        // clear mid-frame with a byte in the same cycle
        send_random(30, 2, 1'b1);
        clear   = 1'b1;
        valid   = 1'b1;
        Byte_in = 8'($urandom);
        tick();
        clear = 1'b0;
        valid = 1'b0;
        m_bytes.delete();
        check("clear_idx", 64'(byte_idx), 64'd0);
        check("clear_busy", 64'(busy), 64'd0);
        repeat (T + 5) tick();
        check("clear_no_fe", 64'(got_fe), 64'(m_fe));
        send_random(48, 4, 1'b0);
        repeat (3) tick();
        check_shown("after_clear");

        // clear landing in the commit cycle must not cancel the commit
        send_random(48, 3, 1'b1);
        clear   = 1'b1;
        valid   = 1'b1;
        Byte_in = 8'($urandom);
        tick();
        clear = 1'b0;
        valid = 1'b0;
        check("cc_idx", 64'(byte_idx), 64'd0);
        check("cc_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        check("cc_fv_count", 64'(got_fv), 64'(m_fv));
        check_shown("cc");

        // Asynchronous reset mid-frame, away from any clock edge
        send_random(40, 2, 1'b1);
        #2;
        sys_rst = 1'b0;
        #1;
        m_bytes.delete();
        for (int i = 0; i < 6; i++) m_shown[i] = '0;
        check_shown("async_rst");
        check("async_idx", 64'(byte_idx), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_fv", 64'(frame_valid), 64'd0);
        repeat (2) tick();
        sys_rst = 1'b1;
        tick();
        send_random(48, 6, 1'b0);
        repeat (3) tick();
        check_shown("after_rst");

        check("final_fv_count", 64'(got_fv), 64'(m_fv));
        check("final_fe_count", 64'(got_fe), 64'(m_fe));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/results_receiver.md
# results_receiver

Byte-stream receiver for correlator result frames: the receive-side counterpart of the results sender. It takes received UART bytes, reassembles the six 64-bit correlation sums, and presents them as one atomically updated, validated frame. It sits behind a UART receiver in loopback/verification builds and on a companion board that collects correlator output. An inter-byte timeout resynchronises the block on truncated frames.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 100000: idle sys_clk cycles allowed between bytes inside a frame before the partial frame is discarded (1 ms at 100 MHz; one byte at 115200 baud takes about 8680 cycles).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- valid  in  1  one-cycle strobe: Byte_in holds a new received byte.
- Byte_in  in  8  received byte; sampled only when valid=1.
- clear  in  1  synchronous abort; discards any partial frame.
- sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90  out  64 each  last complete frame.
- frame_valid  out  1  one-cycle pulse when all six sums update.
- frame_err  out  1  one-cycle pulse when a partial frame is dropped on timeout.
- busy  out  1  high while a frame is partially received.
- byte_idx  out  6  bytes of the current frame received so far, 0..47.

## Operation

- Frame format: 48 bytes with no header. The words arrive in this order: sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90. Each word is sent MSB byte first.
- Datapath:
  - Each byte shifts into a 64-bit shift register.
  - After the 8th byte of a word, the completed word goes to shadow slot byte_idx[5:3].
  - Output registers change only in COMMIT, so outputs always hold a whole, consistent frame.
- States:
  - IDLE: busy=0, byte_idx=0.
    - valid → shift in byte, byte_idx=1, go to RECV.
  - RECV: busy=1.
    - valid → shift in byte, byte_idx+1, timeout counter cleared.
    - 48th byte → go to COMMIT, byte_idx=0.
    - Timeout counter reaches TIMEOUT_CYCLES-1 with no valid → pulse frame_err, discard shadow, go to IDLE. Output registers are unchanged.
  - COMMIT (one cycle): copy all six shadow slots to the outputs; frame_valid=1.
    - valid in this cycle → accept the byte as byte 1 of the next frame and go to RECV. No byte may be lost.
    - Otherwise go to IDLE.
- clear: any state → IDLE next edge; byte_idx=0, timeout counter=0, no frame_err, no frame_valid.
- Priority:
  - clear beats valid.
  - valid beats timeout in the same cycle.
  - COMMIT's frame_valid is not cancelled by clear in that cycle; clear only resets the next frame.
- Timeout counter: ceil(log2(TIMEOUT_CYCLES)) bits, counts only in RECV, saturates.

## Timing

- Reset (sys_rst=0, asynchronous):
  - state=IDLE.
  - All six sums = 64'h0.
  - frame_valid=0, frame_err=0, busy=0, byte_idx=0.
  - Shadow and shift registers = 0.
- Byte accept: valid sampled at edge N → byte_idx and busy reflect it after edge N.
- Frame commit: 48th valid sampled at edge N → COMMIT after N → outputs and frame_valid change at edge N+1. frame_valid is high for exactly the cycle N+1..N+2.
- Timeout: last byte at edge N → frame_err high for the single cycle after edge N+TIMEOUT_CYCLES.
- Back-to-back valid every cycle is supported. Max throughput is one byte per clock.

## Test plan

- Reset check: after sys_rst, all sums are 0 and all strobes are low. Send 48 bytes 0x00..0x2F, spaced 8680 cycles:
  - sum_x_2=64'h0001020304050607, sum_y_y90=64'h28292A2B2C2D2E2F.
  - Exactly one frame_valid pulse, 1 cycle after the last byte.
- Truncation: send 20 bytes, then idle TIMEOUT_CYCLES:
  - frame_err pulses once, busy falls, outputs keep the previous frame.
  - A following full frame is received correctly.
- Back-to-back frames: send 96 bytes with valid high every cycle, the 49th byte landing in the COMMIT cycle:
  - Two frame_valid pulses 48 cycles apart; the second frame is correct.
- clear mid-frame: assert clear at byte_idx=30, with valid high in the same cycle:
  - Byte is dropped, byte_idx=0, no frame_err.
  - The next 48 bytes form a correct frame.
- Async reset mid-frame: deassert-assert sys_rst at byte_idx=40:
  - Immediate return to reset values with no clock edge needed.
  - Previous output frame cleared to 0.
